// File: rtl/cell_loader.sv
// Purpose : packs a serial RGB pixel stream into the cellA/cellB matrices of an
//           instruction word, tags it with an opcode and issues it to the core.
// Latency : iw_valid rises on the clk edge that accepts the last cellB pixel.
// Backpressure: op_ready/pix_ready are functions of state only; the issued word
//           is held bit-stable until iw_ready. Nothing is dropped or reordered.
//
// Ports:
//   clk, reset_n           clock (posedge) and async active-low reset
//   op_valid/op_ready      opcode handshake, op_code latched into iw.opcode
//   pix_valid/pix_ready    pixel handshake, pix_data in raster order
//   iw_valid/iw_ready      instruction word handshake, iw = {opcode, cellA, cellB}
//   busy                   high whenever the loader is not idle
//   pix_idx                next pixel slot inside the cell being filled
//   abort                  (only with CELL_LOADER_ABORT_EN) cancels a load in progress
// Optional feature macro: CELL_LOADER_ABORT_EN

package image_processing_pkg;
  localparam int MAT_DIM = 3;
  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [MAT_DIM-1:0][MAT_DIM-1:0] matrix_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_AVG = 3'd4
  } opcodes_t;

  typedef struct packed {
    opcodes_t opcode;
    matrix_t  cellA;
    matrix_t  cellB;
  } instruction_t;
endpackage

module cell_loader
  import image_processing_pkg::*;
#(
  parameter int CELL_DIM = MAT_DIM,
  parameter int PIX_W    = PIXEL_W,
  localparam int CNT_W   = $clog2(CELL_DIM*CELL_DIM+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  opcodes_t         op_code,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             iw_valid,
  input  logic             iw_ready,
  output instruction_t     iw,
  output logic             busy,
  output logic [CNT_W-1:0] pix_idx
`ifdef CELL_LOADER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int LAST  = CELL_DIM*CELL_DIM - 1;
  localparam int IDX_W = (CELL_DIM > 1) ? $clog2(CELL_DIM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_pix_idx;
  instruction_t       r_iw;

  logic               w_loading;
  logic               w_abort_load;
  logic               w_op_hs;
  logic               w_pix_hs;
  logic               w_last;
  logic [IDX_W-1:0]   w_row;
  logic [IDX_W-1:0]   w_col;

`ifdef CELL_LOADER_ABORT_EN
  // Abort only bites while a cell is being filled; an issued word is never retracted.
  assign w_abort_load = abort & w_loading;
`else
  assign w_abort_load = 1'b0;
`endif

  // Ready signals come from state only, so no valid->ready combinational path exists.
  assign w_loading = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign op_ready  = (r_state == S_IDLE);
  assign pix_ready = w_loading;
  assign iw_valid  = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign pix_idx   = r_pix_idx;
  assign iw        = r_iw;

  assign w_op_hs  = op_valid & op_ready;
  // A pixel offered in the abort cycle is discarded.
  assign w_pix_hs = pix_valid & pix_ready & ~w_abort_load;
  assign w_last   = (r_pix_idx == CNT_W'(LAST));

  // Raster order: column index runs fastest.
  assign w_row = IDX_W'(r_pix_idx / CNT_W'(CELL_DIM));
  assign w_col = IDX_W'(r_pix_idx % CNT_W'(CELL_DIM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_op_hs) w_state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (w_pix_hs && w_last) w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (w_pix_hs && w_last) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (iw_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort_load) w_state_nxt = S_IDLE;
  end

  // Matrix contents are never cleared except by reset; they persist across words
  // and across aborts until overwritten by new pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_idx <= '0;
      r_iw      <= '0;
    end else begin
      if (w_op_hs) begin
        r_iw.opcode <= op_code;
        r_pix_idx   <= '0;
      end
      if (w_abort_load) begin
        r_pix_idx <= '0;
      end else if (w_pix_hs) begin
        if (r_state == S_LOAD_A) begin
          r_iw.cellA[w_row][w_col] <= pixel_t'(pix_data);
        end else begin
          r_iw.cellB[w_row][w_col] <= pixel_t'(pix_data);
        end
        r_pix_idx <= w_last ? '0 : r_pix_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cell_loader.sv
module tb_cell_loader;
  import image_processing_pkg::*;

  localparam int D = 3;
  localparam int N = D*D;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  opcodes_t     op_code = OP_NOP;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  pixel_t       pix_data = '0;
  logic         iw_valid;
  logic         iw_ready = 1'b0;
  instruction_t iw;
  logic         busy;
  logic [3:0]   pix_idx;
`ifdef CELL_LOADER_ABORT_EN
  logic         abort = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  pixel_t stim[$];

  always #5 clk = ~clk;

  cell_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .iw_valid  (iw_valid),
    .iw_ready  (iw_ready),
    .iw        (iw),
    .busy      (busy),
    .pix_idx   (pix_idx)
`ifdef CELL_LOADER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Reference word: pixel k of a cell lands at row k/D, column k%D.
  function automatic instruction_t build_iw(input opcodes_t op, input pixel_t px[$]);
    instruction_t e;
    e = '0;
    e.opcode = op;
    for (int k = 0; k < N; k++) begin
      e.cellA[k/D][k%D] = px[k];
      e.cellB[k/D][k%D] = px[N+k];
    end
    return e;
  endfunction

  task automatic fill_stim(input bit ramp);
    stim.delete();
    for (int k = 0; k < 2*N; k++) stim.push_back(ramp ? pixel_t'(k+1) : pixel_t'($urandom));
  endtask

  task automatic do_reset;
    op_valid = 0; pix_valid = 0; iw_ready = 0;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic do_op(input opcodes_t op);
    int n;
    n = 0;
    op_valid = 1; op_code = op;
    while (op_ready !== 1'b1) begin
      if (n == 60) begin
        vectors++; errors++;
        $display("FAIL op_accept_timeout: op_ready=%b after %0d cycles, required 1", op_ready, n);
        break;
      end
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    op_valid = 0;
  endtask

  // Drives stim[first .. first+n-1]; with stall, an idle cycle precedes every pixel.
  task automatic send_pix(input int first, input int n, input bit stall, output int cycles);
    int w;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        pix_valid = 0;
        @(posedge clk); #1; cycles++;
      end
      pix_valid = 1; pix_data = stim[first+i];
      w = 0;
      while (pix_ready !== 1'b1) begin
        if (w == 60) begin
          vectors++; errors++;
          $display("FAIL pix_accept_timeout: pix_ready=%b at pixel %0d, required 1", pix_ready, first+i);
          break;
        end
        @(posedge clk); #1; w++; cycles++;
      end
      @(posedge clk); #1; cycles++;
    end
    pix_valid = 0;
  endtask

  task automatic test_reset;
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b need 1", op_ready); end
    vectors++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b need 0", pix_ready); end
    vectors++; if (iw_valid !== 1'b0) begin errors++; $display("FAIL reset_iw_valid: got %b need 0", iw_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    vectors++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL reset_pix_idx: got %0d need 0", pix_idx); end
    vectors++; if (iw !== instruction_t'('0)) begin errors++; $display("FAIL reset_iw: got %h need 0", iw); end
    reset_n = 1;
    // Reset while cellB is partly filled (pix_idx=4).
    fill_stim(0);
    do_op(OP_ADD);
    send_pix(0, N+4, 0, cyc);
    vectors++; if (pix_idx !== 4'd4) begin errors++; $display("FAIL midload_pix_idx: got %0d need 4", pix_idx); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midload_busy: got %b need 1", busy); end
    #2 reset_n = 0;
    #1;
    vectors++; if (iw_valid !== 1'b0) begin errors++; $display("FAIL async_iw_valid: got %b need 0", iw_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b need 0", busy); end
    vectors++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL async_pix_ready: got %b need 0", pix_ready); end
    vectors++; if (op_ready !== 1'b1) begin errors++; $display("FAIL async_op_ready: got %b need 1", op_ready); end
    vectors++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL async_pix_idx: got %0d need 0", pix_idx); end
    vectors++; if (iw !== instruction_t'('0)) begin errors++; $display("FAIL async_iw: got %h need 0", iw); end
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_fill(input string name, input opcodes_t op, input bit stall, input int lat);
    int cyc;
    instruction_t e;
    iw_ready = 1;
    do_op(op);
    send_pix(0, 2*N, stall, cyc);
    e = build_iw(op, stim);
    vectors++; if (cyc !== lat) begin errors++; $display("FAIL %s_latency: got %0d cycles need %0d", name, cyc, lat); end
    vectors++; if (iw_valid !== 1'b1) begin errors++; $display("FAIL %s_iw_valid: got %b need 1", name, iw_valid); end
    vectors++; if (iw !== e) begin errors++; $display("FAIL %s_iw: got %h need %h", name, iw, e); end
    @(posedge clk); #1;
    vectors++; if (iw_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_release: iw_valid=%b busy=%b need 0 0", name, iw_valid, busy);
    end
    iw_ready = 0;
  endtask

  task automatic test_basic;
    stim.delete();
    for (int k = 0; k < N; k++) stim.push_back(24'h000000);
    for (int k = 0; k < N; k++) stim.push_back(24'h00FF00);
    test_fill("basic", OP_ADD, 0, 2*N);
    vectors++; if (iw.cellB[1][1] !== 24'h00FF00 || iw.cellA[2][0] !== 24'h000000 || iw.opcode !== OP_ADD) begin
      errors++; $display("FAIL basic_cells: A20=%h B11=%h op=%0d need 000000 00ff00 %0d", iw.cellA[2][0], iw.cellB[1][1], iw.opcode, OP_ADD);
    end
  endtask

  task automatic test_raster;
    fill_stim(1);
    test_fill("raster", OP_MUL, 0, 2*N);
    vectors++; if (iw.cellA[0][0] !== 24'd1) begin errors++; $display("FAIL raster_a00: got %h need 1", iw.cellA[0][0]); end
    vectors++; if (iw.cellA[0][2] !== 24'd3) begin errors++; $display("FAIL raster_a02: got %h need 3", iw.cellA[0][2]); end
    vectors++; if (iw.cellA[1][0] !== 24'd4) begin errors++; $display("FAIL raster_a10: got %h need 4", iw.cellA[1][0]); end
    vectors++; if (iw.cellA[2][2] !== 24'd9) begin errors++; $display("FAIL raster_a22: got %h need 9", iw.cellA[2][2]); end
  endtask

  task automatic test_stalls;
    stim.delete();
    for (int k = 0; k < N; k++) stim.push_back(24'h000000);
    for (int k = 0; k < N; k++) stim.push_back(24'h00FF00);
    test_fill("stall", OP_ADD, 1, 4*N);
  endtask

  task automatic test_backpressure;
    int cyc;
    instruction_t e;
    fill_stim(0);
    iw_ready = 0;
    do_op(OP_SUB);
    send_pix(0, 2*N, 0, cyc);
    e = build_iw(OP_SUB, stim);
    op_valid = 1; op_code = OP_AVG;
    for (int c = 0; c < 20; c++) begin
      pix_valid = 1; pix_data = pixel_t'($urandom);
      vectors++; if (iw !== e || iw_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d: iw_valid=%b iw=%h need 1 %h", c, iw_valid, iw, e);
      end
      vectors++; if (pix_ready !== 1'b0 || op_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready c%0d: pix_ready=%b op_ready=%b need 0 0", c, pix_ready, op_ready);
      end
      @(posedge clk); #1;
    end
    iw_ready = 1;
    @(posedge clk); #1;
    iw_ready = 0;
    vectors++; if (iw_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_hs: iw_valid=%b busy=%b op_ready=%b need 0 0 1", iw_valid, busy, op_ready);
    end
    @(posedge clk); #1;
    op_valid = 0; pix_valid = 0;
    vectors++; if (busy !== 1'b1 || iw.opcode !== OP_AVG || pix_idx !== 4'd0) begin
      errors++; $display("FAIL bp_pending_op: busy=%b op=%0d pix_idx=%0d need 1 %0d 0", busy, iw.opcode, pix_idx, OP_AVG);
    end
    vectors++; if (iw.cellA !== e.cellA) begin
      errors++; $display("FAIL bp_persist: cellA=%h need %h", iw.cellA, e.cellA);
    end
    do_reset();
  endtask

  task automatic test_back_to_back;
    int first_iw, second_iw;
    first_iw = -1; second_iw = -1;
    op_valid = 1; op_code = OP_ADD; pix_valid = 1; pix_data = 24'h123456; iw_ready = 1;
    for (int c = 0; c < 50; c++) begin
      if (iw_valid === 1'b1) begin
        if (first_iw < 0) first_iw = c;
        else if (second_iw < 0) second_iw = c;
      end
      @(posedge clk); #1;
    end
    vectors++; if (first_iw !== 1 + 2*N) begin errors++; $display("FAIL b2b_first: got cycle %0d need %0d", first_iw, 1 + 2*N); end
    vectors++; if (second_iw - first_iw !== 2*N + 2) begin
      errors++; $display("FAIL b2b_period: got %0d need %0d", second_iw - first_iw, 2*N + 2);
    end
    do_reset();
  endtask

  task automatic test_random;
    opcodes_t     op_q[$];
    pixel_t       pix_q[$];
    instruction_t e;
    bit e_op_rdy, e_pix_rdy, e_iw_vld;
    int words;
    words = 0;
    for (int c = 0; c < 3000; c++) begin
      e_op_rdy  = (op_q.size() == 0);
      e_pix_rdy = (op_q.size() == 1) && (pix_q.size() < 2*N);
      e_iw_vld  = (op_q.size() == 1) && (pix_q.size() == 2*N);
      vectors++; if (op_ready !== e_op_rdy || pix_ready !== e_pix_rdy || iw_valid !== e_iw_vld) begin
        errors++; $display("FAIL rnd_ctrl c%0d: op_ready=%b pix_ready=%b iw_valid=%b need %b %b %b",
                           c, op_ready, pix_ready, iw_valid, e_op_rdy, e_pix_rdy, e_iw_vld);
      end
      vectors++; if (busy !== !e_op_rdy || pix_idx !== 4'(pix_q.size() % N)) begin
        errors++; $display("FAIL rnd_busy_idx c%0d: busy=%b pix_idx=%0d need %b %0d", c, busy, pix_idx, !e_op_rdy, pix_q.size() % N);
      end
      if (e_iw_vld) begin
        e = build_iw(op_q[0], pix_q);
        vectors++; if (iw !== e) begin errors++; $display("FAIL rnd_iw c%0d: got %h need %h", c, iw, e); end
      end
      op_valid  = ($urandom_range(0, 2) == 0);
      op_code   = opcodes_t'(3'($urandom_range(0, 4)));
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data  = pixel_t'($urandom);
      iw_ready  = ($urandom_range(0, 3) == 0);
      if (e_iw_vld && iw_ready) begin
        op_q.delete(); pix_q.delete(); words++;
      end
      if (e_op_rdy && op_valid) op_q.push_back(op_code);
      if (e_pix_rdy && pix_valid) pix_q.push_back(pix_data);
      @(posedge clk); #1;
    end
    vectors++; if (words < 10) begin errors++; $display("FAIL rnd_words: got %0d words need >= 10", words); end
    do_reset();
  endtask

`ifdef CELL_LOADER_ABORT_EN
  task automatic test_abort;
    int cyc;
    instruction_t e;
    fill_stim(0);
    do_op(OP_ADD);
    send_pix(0, 5, 0, cyc);
    pix_valid = 1; pix_data = 24'hDEAD00; abort = 1;
    @(posedge clk); #1;
    abort = 0; pix_valid = 0;
    vectors++; if (busy !== 1'b0 || pix_idx !== 4'd0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL abort_load: busy=%b pix_idx=%0d op_ready=%b need 0 0 1", busy, pix_idx, op_ready);
    end
    fill_stim(0);
    do_op(OP_SUB);
    send_pix(0, 2*N, 0, cyc);
    e = build_iw(OP_SUB, stim);
    vectors++; if (iw !== e) begin errors++; $display("FAIL abort_reload: got %h need %h", iw, e); end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    vectors++; if (iw_valid !== 1'b1 || iw !== e) begin
      errors++; $display("FAIL abort_issue: iw_valid=%b iw=%h need 1 %h", iw_valid, iw, e);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_raster();
    test_backpressure();
    test_stalls();
    test_back_to_back();
`ifdef CELL_LOADER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
